// File: rtl/regwb_pkg.sv
// Shared types and widths for the register-file write-back arbiter.
//   XLEN     : data width
//   REG_AW   : register address width
//   NREGS    : number of architectural registers (x0 hard-wired zero)
//   gnt_e    : which write-back stream won the last grant
//   wb_req_t : one write-back request (valid, destination, data)
package regwb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREGS  = 1 << REG_AW;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } gnt_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wdata;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Handshake/bus bundle between the issue stage, the two write-back streams,
// the register-file write port and the write-back arbiter.
//   master : issue stage / write-back streams / environment side
//   slave  : regfile_wb_arbiter side
interface regfile_wb_arbiter_if;
  import regwb_pkg::*;

  // Issue-stage reservation
  logic              issue_valid;
  logic [REG_AW-1:0] issue_rd;
  logic              issue_ready;
  // Read-port hazard lookup
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic              rs1_busy;
  logic              rs2_busy;
  logic [XLEN-1:0]   rs1_fwd;
  logic [XLEN-1:0]   rs2_fwd;
  // ALU write-back stream
  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_wdata;
  logic              alu_ready;
  // LSU write-back stream
  logic              lsu_valid;
  logic [REG_AW-1:0] lsu_rd;
  logic [XLEN-1:0]   lsu_wdata;
  logic              lsu_ready;
  // Register-file write port and error flag
  logic [REG_AW-1:0] rf_rd;
  logic [XLEN-1:0]   rf_wdata;
  logic              rf_regwrite;
  logic              wb_err;

  modport master (
    output issue_valid, issue_rd, rs1, rs2,
           alu_valid, alu_rd, alu_wdata,
           lsu_valid, lsu_rd, lsu_wdata,
    input  issue_ready, rs1_busy, rs2_busy, rs1_fwd, rs2_fwd,
           alu_ready, lsu_ready, rf_rd, rf_wdata, rf_regwrite, wb_err
  );

  modport slave (
    input  issue_valid, issue_rd, rs1, rs2,
           alu_valid, alu_rd, alu_wdata,
           lsu_valid, lsu_rd, lsu_wdata,
    output issue_ready, rs1_busy, rs2_busy, rs1_fwd, rs2_fwd,
           alu_ready, lsu_ready, rf_rd, rf_wdata, rf_regwrite, wb_err
  );

endinterface

// File: rtl/regwb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on commit.
//   clk, rst_n      : clock, async active-low reset
//   i_set_valid/rd  : issue reservation request
//   i_clr_valid/rd  : commit (register-file write this cycle)
//   i_rs1, i_rs2    : read addresses to look up
//   i_look_rd       : destination of the current write-back grant
//   o_issue_ready   : reservation can be accepted this cycle
//   o_rs1/2_busy    : read address has an uncommitted write
//   o_look_pending  : granted destination is currently pending
module regwb_scoreboard
  import regwb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_set_valid,
  input  logic [REG_AW-1:0] i_set_rd,
  input  logic              i_clr_valid,
  input  logic [REG_AW-1:0] i_clr_rd,
  input  logic [REG_AW-1:0] i_rs1,
  input  logic [REG_AW-1:0] i_rs2,
  input  logic [REG_AW-1:0] i_look_rd,
  output logic              o_issue_ready,
  output logic              o_rs1_busy,
  output logic              o_rs2_busy,
  output logic              o_look_pending
);

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_clr_mask;
  logic [NREGS-1:0] w_set_mask;
  logic             w_set;

  assign w_clr_mask = i_clr_valid ? (NREGS'(1) << i_clr_rd) : '0;

  // A register being committed this cycle may be re-reserved in the same cycle.
  assign o_issue_ready = !r_pending[i_set_rd] || w_clr_mask[i_set_rd];

  // x0 is accepted but never tracked.
  assign w_set      = i_set_valid && o_issue_ready && (i_set_rd != '0);
  assign w_set_mask = w_set ? (NREGS'(1) << i_set_rd) : '0;

  assign o_rs1_busy     = r_pending[i_rs1] && (i_rs1 != '0);
  assign o_rs2_busy     = r_pending[i_rs2] && (i_rs2 != '0);
  assign o_look_pending = r_pending[i_look_rd];

  // Set applied after clear so a same-cycle set/clear leaves the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter in front of the register-file write port: round-robin
// between ALU and LSU streams, registered write drive, pending-write
// scoreboard for RAW stalls and a sticky unexpected-write-back flag.
//   clk   : clock, rising edge
//   rst_n : async active-low reset
//   bus   : regfile_wb_arbiter_if.slave (issue, read lookup, ALU/LSU
//           write-back handshakes, register-file write port, wb_err)
// Optional: REGWB_BYPASS_EN forwards the committing write data to matching
// read ports and drops their busy in the commit cycle.
module regfile_wb_arbiter
  import regwb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  wb_req_t           w_alu;
  wb_req_t           w_lsu;
  wb_req_t           w_gnt_req;
  logic              w_alu_gnt;
  logic              w_lsu_gnt;
  logic              w_any_gnt;
  logic              w_gnt_pending;
  logic              w_rs1_busy_sb;
  logic              w_rs2_busy_sb;
  gnt_e              r_last_gnt;
  logic [REG_AW-1:0] r_rf_rd;
  logic [XLEN-1:0]   r_rf_wdata;
  logic              r_rf_regwrite;
  logic              r_wb_err;

  assign w_alu = '{valid: bus.alu_valid, rd: bus.alu_rd, wdata: bus.alu_wdata};
  assign w_lsu = '{valid: bus.lsu_valid, rd: bus.lsu_rd, wdata: bus.lsu_wdata};

  // Under contention the stream that did not win last time gets the port.
  assign w_alu_gnt = w_alu.valid && (!w_lsu.valid || (r_last_gnt == GNT_LSU));
  assign w_lsu_gnt = w_lsu.valid && !w_alu_gnt;
  assign w_any_gnt = w_alu_gnt || w_lsu_gnt;
  assign w_gnt_req = w_alu_gnt ? w_alu : w_lsu;

  assign bus.alu_ready = w_alu_gnt;
  assign bus.lsu_ready = w_lsu_gnt;

  regwb_scoreboard u_scoreboard (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_set_valid    (bus.issue_valid),
    .i_set_rd       (bus.issue_rd),
    .i_clr_valid    (r_rf_regwrite),
    .i_clr_rd       (r_rf_rd),
    .i_rs1          (bus.rs1),
    .i_rs2          (bus.rs2),
    .i_look_rd      (w_gnt_req.rd),
    .o_issue_ready  (bus.issue_ready),
    .o_rs1_busy     (w_rs1_busy_sb),
    .o_rs2_busy     (w_rs2_busy_sb),
    .o_look_pending (w_gnt_pending)
  );

  // Output register for the register-file write port and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt    <= GNT_LSU;
      r_rf_rd       <= '0;
      r_rf_wdata    <= '0;
      r_rf_regwrite <= 1'b0;
      r_wb_err      <= 1'b0;
    end else begin
      r_rf_regwrite <= w_any_gnt && (w_gnt_req.rd != '0);
      if (w_any_gnt) begin
        r_last_gnt <= w_alu_gnt ? GNT_ALU : GNT_LSU;
        r_rf_rd    <= w_gnt_req.rd;
        r_rf_wdata <= w_gnt_req.wdata;
        if ((w_gnt_req.rd != '0) && !w_gnt_pending) r_wb_err <= 1'b1;
      end
    end
  end

  assign bus.rf_rd       = r_rf_rd;
  assign bus.rf_wdata    = r_rf_wdata;
  assign bus.rf_regwrite = r_rf_regwrite;
  assign bus.wb_err      = r_wb_err;

`ifdef REGWB_BYPASS_EN
  logic w_rs1_hit;
  logic w_rs2_hit;

  // Read address matches the write being committed this cycle.
  assign w_rs1_hit = r_rf_regwrite && (r_rf_rd == bus.rs1) && (bus.rs1 != '0);
  assign w_rs2_hit = r_rf_regwrite && (r_rf_rd == bus.rs2) && (bus.rs2 != '0);

  assign bus.rs1_busy = w_rs1_busy_sb && !w_rs1_hit;
  assign bus.rs2_busy = w_rs2_busy_sb && !w_rs2_hit;
  assign bus.rs1_fwd  = w_rs1_hit ? r_rf_wdata : '0;
  assign bus.rs2_fwd  = w_rs2_hit ? r_rf_wdata : '0;
`else
  assign bus.rs1_busy = w_rs1_busy_sb;
  assign bus.rs2_busy = w_rs2_busy_sb;
  assign bus.rs1_fwd  = '0;
  assign bus.rs2_fwd  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
  import regwb_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n           = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.rs1         = '0;
    bus.rs2         = '0;
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_wdata   = '0;
    bus.lsu_valid   = 1'b0;
    bus.lsu_rd      = '0;
    bus.lsu_wdata   = '0;

    // Reset state
    tick();
    tick();
    check_eq("rst_regwrite", 32'(bus.rf_regwrite), 32'd0);
    check_eq("rst_rf_rd",    32'(bus.rf_rd),       32'd0);
    check_eq("rst_wdata",    bus.rf_wdata,         32'd0);
    check_eq("rst_wb_err",   32'(bus.wb_err),      32'd0);
    rst_n = 1'b1;
    tick();

    // Reserve x3 and x4
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd3;
    check_eq("issue3_ready", 32'(bus.issue_ready), 32'd1);
    tick();
    bus.issue_rd    = 5'd4;
    tick();
    bus.issue_valid = 1'b0;
    bus.rs1 = 5'd3;
    bus.rs2 = 5'd4;
    #1;
    check_eq("busy_rs1_x3", 32'(bus.rs1_busy), 32'd1);
    check_eq("busy_rs2_x4", 32'(bus.rs2_busy), 32'd1);

    // Contention: both streams valid for 4 cycles, grants alternate.
    // x3/x4 are re-reserved while their earlier write commits.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_wdata = 32'h1111_0003;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_wdata = 32'h2222_0004;
    for (int k = 0; k < 4; k++) begin
      bus.issue_valid = (k == 1) || (k == 2);
      bus.issue_rd    = (k == 1) ? 5'd3 : 5'd4;
      #1;
      check_eq($sformatf("cont%0d_alu_ready", k), 32'(bus.alu_ready), 32'((k % 2) == 0));
      check_eq($sformatf("cont%0d_lsu_ready", k), 32'(bus.lsu_ready), 32'((k % 2) == 1));
      if (k == 1 || k == 2)
        check_eq($sformatf("cont%0d_collide_ready", k), 32'(bus.issue_ready), 32'd1);
      tick();
      check_eq($sformatf("cont%0d_rf_rd", k), 32'(bus.rf_rd), (k % 2 == 0) ? 32'd3 : 32'd4);
      check_eq($sformatf("cont%0d_regwrite", k), 32'(bus.rf_regwrite), 32'd1);
    end
    bus.issue_valid = 1'b0;
    bus.alu_valid   = 1'b0;
    bus.lsu_valid   = 1'b0;
    tick();
    check_eq("idle_regwrite", 32'(bus.rf_regwrite), 32'd0);
    check_eq("cont_no_err",   32'(bus.wb_err),      32'd0);
    check_eq("x4_cleared",    32'(bus.rs2_busy),    32'd0);

    // RAW stall on x5
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd5;
    tick();
    bus.issue_valid = 1'b0;
    bus.rs1 = 5'd5;
    #1;
    check_eq("raw_busy_issued", 32'(bus.rs1_busy), 32'd1);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_wdata = 32'hDEAD_BEEF;
    #1;
    check_eq("raw_alu_ready", 32'(bus.alu_ready), 32'd1);
    check_eq("raw_busy_grant", 32'(bus.rs1_busy), 32'd1);
    tick();
    bus.alu_valid = 1'b0;
    #1;
    check_eq("raw_commit_rd",    32'(bus.rf_rd), 32'd5);
    check_eq("raw_commit_wdata", bus.rf_wdata,   32'hDEAD_BEEF);
`ifdef REGWB_BYPASS_EN
    check_eq("raw_commit_busy", 32'(bus.rs1_busy), 32'd0);
    check_eq("raw_commit_fwd",  bus.rs1_fwd,       32'hDEAD_BEEF);
`else
    check_eq("raw_commit_busy", 32'(bus.rs1_busy), 32'd1);
    check_eq("raw_commit_fwd",  bus.rs1_fwd,       32'd0);
`endif
    check_eq("raw_rs2_fwd", bus.rs2_fwd, 32'd0);
    tick();
    check_eq("raw_after_busy", 32'(bus.rs1_busy), 32'd0);
    check_eq("raw_after_fwd",  bus.rs1_fwd,       32'd0);

    // Issue/commit collision on x7
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd7;
    tick();
    #1;
    check_eq("x7_pending_block", 32'(bus.issue_ready), 32'd0);
    bus.issue_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_wdata = 32'h0000_0707;
    tick();
    bus.alu_valid   = 1'b0;
    bus.issue_valid = 1'b1;
    #1;
    check_eq("x7_collide_ready", 32'(bus.issue_ready), 32'd1);
    tick();
    bus.issue_valid = 1'b0;
    bus.rs1 = 5'd7;
    #1;
    check_eq("x7_still_pending", 32'(bus.rs1_busy), 32'd1);
    check_eq("x7_no_err",        32'(bus.wb_err),   32'd0);

    // x0 handling
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd0;
    #1;
    check_eq("x0_issue_ready", 32'(bus.issue_ready), 32'd1);
    tick();
    bus.issue_valid = 1'b0;
    bus.rs2 = 5'd0;
    #1;
    check_eq("x0_busy",        32'(bus.rs2_busy), 32'd0);
    check_eq("x0_x7_unchanged", 32'(bus.rs1_busy), 32'd1);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_wdata = 32'h0000_00AA;
    #1;
    check_eq("x0_alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    bus.alu_valid = 1'b0;
    check_eq("x0_regwrite", 32'(bus.rf_regwrite), 32'd0);
    check_eq("x0_wb_err",   32'(bus.wb_err),      32'd0);

    // Unexpected write-back to x9
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_wdata = 32'h0000_0009;
    #1;
    check_eq("err_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    tick();
    bus.lsu_valid = 1'b0;
    check_eq("err_regwrite", 32'(bus.rf_regwrite), 32'd1);
    check_eq("err_rf_rd",    32'(bus.rf_rd),       32'd9);
    check_eq("err_set",      32'(bus.wb_err),      32'd1);
    tick();
    tick();
    check_eq("err_sticky", 32'(bus.wb_err), 32'd1);

    // Reset mid-traffic
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_wdata = 32'h7777_7777;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_wdata = 32'h3333_3333;
    tick();
    check_eq("pre_rst_regwrite", 32'(bus.rf_regwrite), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_regwrite", 32'(bus.rf_regwrite), 32'd0);
    check_eq("mid_rst_rf_rd",    32'(bus.rf_rd),       32'd0);
    check_eq("mid_rst_wdata",    bus.rf_wdata,         32'd0);
    check_eq("mid_rst_wb_err",   32'(bus.wb_err),      32'd0);
    check_eq("mid_rst_pending",  32'(bus.rs1_busy),    32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_alu_first", 32'(bus.alu_ready), 32'd1);
    check_eq("post_rst_lsu_wait",  32'(bus.lsu_ready), 32'd0);
    tick();
    check_eq("post_rst_rf_rd", 32'(bus.rf_rd), 32'd7);
    bus.alu_valid = 1'b0;
    bus.lsu_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
